// File: rtl/lfsr.sv
// lfsr: combinational multi-step LFSR/CRC/scrambler engine with optional registered copy
module lfsr #(
    parameter int                    LFSR_WIDTH        = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
    parameter string                 LFSR_CONFIG       = "FIBONACCI",
    parameter bit                    LFSR_FEED_FORWARD = 1'b0,
    parameter bit                    REVERSE           = 1'b0,
    parameter int                    DATA_WIDTH        = 8,
    parameter string                 STYLE             = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out,
    input  logic                  out_en,
    output logic [DATA_WIDTH-1:0] data_out_reg,
    output logic [LFSR_WIDTH-1:0] state_out_reg
);
    localparam int W = LFSR_WIDTH;
    localparam int D = DATA_WIDTH;
    localparam int N = W + D;
    localparam bit GAL = LFSR_CONFIG == "GALOIS";
    localparam bit FF = LFSR_FEED_FORWARD;

    if (!GAL && LFSR_CONFIG != "FIBONACCI") begin : g_bad_cfg
        $error("lfsr: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end

    // Symbolic run of the LFSR: each row is the set of inputs {data_in, state_in} feeding one output bit
    function automatic logic [N-1:0][N-1:0] gen_masks();
        logic [W-1:0][N-1:0] s;
        logic [N-1:0][N-1:0] m;
        logic [N-1:0] one, f, p, b;
        one = '0;
        one[0] = 1'b1;
        m = '0;
        for (int k = 0; k < W; k++) s[k] = one << k;
        for (int i = D - 1; i >= 0; i--) begin
            b = one << (W + i);
            p = '0;
            for (int k = 0; k < W; k++) p = p ^ (LFSR_POLY[k] ? s[k] : '0);
            m[W + i] = (GAL ? s[W-1] : p) ^ b;
            f = FF ? b : m[W + i];
            for (int k = W - 1; k > 0; k--) s[k] = GAL ? s[k-1] ^ (LFSR_POLY[k] ? f : '0) : s[k-1];
            s[0] = GAL ? (LFSR_POLY[0] ? f : '0) : f;
        end
        for (int k = 0; k < W; k++) m[k] = s[k];
        return m;
    endfunction

    logic [D-1:0] d_in, d_out;
    logic [W-1:0] s_in, s_out;

    for (genvar i = 0; i < D; i++) begin : g_rev_d
        assign d_in[i] = REVERSE ? data_in[D-1-i] : data_in[i];
        assign data_out[i] = REVERSE ? d_out[D-1-i] : d_out[i];
    end

    for (genvar i = 0; i < W; i++) begin : g_rev_s
        assign s_in[i] = REVERSE ? state_in[W-1-i] : state_in[i];
        assign state_out[i] = REVERSE ? s_out[W-1-i] : s_out[i];
    end

    if (STYLE == "LOOP") begin : g_loop
        logic [W-1:0] s;
        logic [D-1:0] o;
        logic f;
        always_comb begin
            s = s_in;
            o = '0;
            f = 1'b0;
            for (int i = D - 1; i >= 0; i--) begin
                o[i] = (GAL ? s[W-1] : ^(s & LFSR_POLY)) ^ d_in[i];
                f = FF ? d_in[i] : o[i];
                s = GAL ? (s << 1) ^ (f ? LFSR_POLY : '0) : {s[W-2:0], f};
            end
        end
        assign s_out = s;
        assign d_out = o;
    end else begin : g_reduction
        localparam logic [N-1:0][N-1:0] MASKS = gen_masks();
        logic [N-1:0] v;
        assign v = {d_in, s_in};
        for (genvar k = 0; k < W; k++) begin : g_s
            assign s_out[k] = ^(v & MASKS[k]);
        end
        for (genvar k = 0; k < D; k++) begin : g_d
            assign d_out[k] = ^(v & MASKS[W + k]);
        end
    end

    logic [D-1:0] data_out_reg_d, data_out_reg_q;
    logic [W-1:0] state_out_reg_d, state_out_reg_q;

    always_comb begin
        data_out_reg_d = out_en ? data_out : data_out_reg_q;
        state_out_reg_d = out_en ? state_out : state_out_reg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg_q <= '0;
            state_out_reg_q <= '0;
        end else begin
            data_out_reg_q <= data_out_reg_d;
            state_out_reg_q <= state_out_reg_d;
        end
    end

    assign data_out_reg = data_out_reg_q;
    assign state_out_reg = state_out_reg_q;
endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: randomized self-checking bench for lfsr against a bit-serial reference and a table-free CRC-32 model
module tb_lfsr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_en = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic [31:0] crc_si, crc_di, crc_so, crc_do, crc_so_reg, crc_do_reg;
    logic [31:0] crl_so, crl_do, crl_so_reg, crl_do_reg;
    logic [57:0] sc_si, sc_so, ds_so, sc_so_reg, ds_so_reg;
    logic [63:0] sc_di, sc_do, ds_do, sc_do_reg, ds_do_reg;
    logic [15:0] cm_si;
    logic [23:0] cm_di;
    logic [15:0] cm_so_l [4], cm_so_r [4], cm_so_lq [4], cm_so_rq [4];
    logic [23:0] cm_do_l [4], cm_do_r [4], cm_do_lq [4], cm_do_rq [4];

    lfsr #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .LFSR_FEED_FORWARD(1'b0),
           .REVERSE(1'b1), .DATA_WIDTH(32), .STYLE("AUTO")) u_crc (
        .clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si), .data_out(crc_do), .state_out(crc_so),
        .out_en(out_en), .data_out_reg(crc_do_reg), .state_out_reg(crc_so_reg));

    lfsr #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .LFSR_FEED_FORWARD(1'b0),
           .REVERSE(1'b1), .DATA_WIDTH(32), .STYLE("LOOP")) u_crc_loop (
        .clk(clk), .rst(rst), .data_in(crc_di), .state_in(crc_si), .data_out(crl_do), .state_out(crl_so),
        .out_en(out_en), .data_out_reg(crl_do_reg), .state_out_reg(crl_so_reg));

    lfsr #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"), .LFSR_FEED_FORWARD(1'b0),
           .REVERSE(1'b0), .DATA_WIDTH(64), .STYLE("AUTO")) u_scr (
        .clk(clk), .rst(rst), .data_in(sc_di), .state_in(sc_si), .data_out(sc_do), .state_out(sc_so),
        .out_en(out_en), .data_out_reg(sc_do_reg), .state_out_reg(sc_so_reg));

    lfsr #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"), .LFSR_FEED_FORWARD(1'b1),
           .REVERSE(1'b0), .DATA_WIDTH(64), .STYLE("AUTO")) u_dscr (
        .clk(clk), .rst(rst), .data_in(sc_do), .state_in(sc_si), .data_out(ds_do), .state_out(ds_so),
        .out_en(out_en), .data_out_reg(ds_do_reg), .state_out_reg(ds_so_reg));

    // combo c: bit1 = GALOIS, bit0 = feed-forward; DATA_WIDTH > LFSR_WIDTH on purpose
    for (genvar c = 0; c < 4; c++) begin : g_cmb
        localparam string CFG = (c >= 2) ? "GALOIS" : "FIBONACCI";
        lfsr #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG(CFG), .LFSR_FEED_FORWARD(c % 2 == 1),
               .REVERSE(1'b0), .DATA_WIDTH(24), .STYLE("LOOP")) u_l (
            .clk(clk), .rst(rst), .data_in(cm_di), .state_in(cm_si), .data_out(cm_do_l[c]), .state_out(cm_so_l[c]),
            .out_en(out_en), .data_out_reg(cm_do_lq[c]), .state_out_reg(cm_so_lq[c]));
        lfsr #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG(CFG), .LFSR_FEED_FORWARD(c % 2 == 1),
               .REVERSE(1'b0), .DATA_WIDTH(24), .STYLE("REDUCTION")) u_r (
            .clk(clk), .rst(rst), .data_in(cm_di), .state_in(cm_si), .data_out(cm_do_r[c]), .state_out(cm_so_r[c]),
            .out_en(out_en), .data_out_reg(cm_do_rq[c]), .state_out_reg(cm_so_rq[c]));
    end

    function automatic logic [63:0] revn(input logic [63:0] x, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = x[n-1-i];
        return r;
    endfunction

    // Bit-serial reference following the stepping rules literally, on 64-bit integers
    function automatic void model(input bit gal, input bit ff, input bit rev, input int w, input int dw,
                                  input logic [63:0] poly, input logic [63:0] si, input logic [63:0] di,
                                  output logic [63:0] so, output logic [63:0] dout);
        logic [63:0] s, d, m;
        bit b, f, p;
        m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        s = rev ? revn(si, w) : si;
        d = rev ? revn(di, dw) : di;
        dout = '0;
        for (int i = dw - 1; i >= 0; i--) begin
            b = d[i];
            p = ^(s & poly);
            if (gal) begin
                f = ff ? b : s[w-1] ^ b;
                dout[i] = s[w-1] ^ b;
                s = ((s << 1) ^ (f ? poly : 64'd0)) & m;
            end else begin
                dout[i] = p ^ b;
                s = ((s << 1) | 64'(ff ? b : p ^ b)) & m;
            end
        end
        so = rev ? revn(s, w) : s;
        dout = rev ? revn(dout, dw) : dout;
    endfunction

    // Classic right-shifting reflected CRC-32 register update (no final inversion)
    function automatic logic [31:0] crc_ref(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] c = s ^ d;
        for (int i = 0; i < 32; i++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        out_en = 1'b1;
        crc_si = 32'hFFFFFFFF;
        crc_di = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (crc_so_reg !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state_reg got %h want %h", crc_so_reg, 32'h0);
        end
        n_checks++;
        if (crc_do_reg !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data_reg got %h want %h", crc_do_reg, 32'h0);
        end
        out_en = 1'b0;
    endtask

    task automatic test_crc_vectors();
        logic [63:0] so, dout;
        logic [31:0] vs [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] vd [3] = '{32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] ve [3] = '{32'hDEBB20E3, 32'h0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            crc_si = vs[i];
            crc_di = vd[i];
            #1;
            model(1'b1, 1'b0, 1'b1, 32, 32, 64'h04C11DB7, 64'(vs[i]), 64'(vd[i]), so, dout);
            n_checks++;
            if (crc_so !== ve[i]) begin
                n_fail++;
                $display("FAIL crc_vec%0d state_out got %h want %h", i, crc_so, ve[i]);
            end
            n_checks++;
            if (crc_do !== 32'(dout)) begin
                n_fail++;
                $display("FAIL crc_vec%0d data_out got %h want %h", i, crc_do, 32'(dout));
            end
        end
        n_checks++;
        if (crc_do !== 32'h0) begin
            n_fail++;
            $display("FAIL crc_zero data_out got %h want %h", crc_do, 32'h0);
        end
    endtask

    task automatic test_crc_random();
        logic [63:0] so, dout;
        for (int i = 0; i < 200; i++) begin
            crc_si = (i % 2 == 0) ? 32'hFFFFFFFF : $urandom;
            crc_di = $urandom;
            #1;
            model(1'b1, 1'b0, 1'b1, 32, 32, 64'h04C11DB7, 64'(crc_si), 64'(crc_di), so, dout);
            n_checks++;
            if (crc_so !== crc_ref(crc_si, crc_di) || crl_so !== crc_so) begin
                n_fail++;
                $display("FAIL crc_rand state got %h/%h want %h", crc_so, crl_so, crc_ref(crc_si, crc_di));
            end
            n_checks++;
            if (crc_do !== 32'(dout) || crl_do !== 32'(dout)) begin
                n_fail++;
                $display("FAIL crc_rand data got %h/%h want %h", crc_do, crl_do, 32'(dout));
            end
        end
    endtask

    task automatic test_linearity();
        logic [31:0] as, ad, bs, bd, aso, ado, bso, bdo;
        for (int i = 0; i < 50; i++) begin
            as = $urandom;
            ad = $urandom;
            bs = $urandom;
            bd = $urandom;
            crc_si = as;
            crc_di = ad;
            #1;
            aso = crc_so;
            ado = crc_do;
            crc_si = bs;
            crc_di = bd;
            #1;
            bso = crc_so;
            bdo = crc_do;
            crc_si = as ^ bs;
            crc_di = ad ^ bd;
            #1;
            n_checks++;
            if (crc_so !== (aso ^ bso) || crc_do !== (ado ^ bdo)) begin
                n_fail++;
                $display("FAIL linearity got %h/%h want %h/%h", crc_so, crc_do, aso ^ bso, ado ^ bdo);
            end
        end
    endtask

    task automatic test_scrambler();
        logic [63:0] so, dout;
        for (int i = 0; i < 100; i++) begin
            sc_si = 58'({$urandom, $urandom});
            sc_di = {$urandom, $urandom};
            #1;
            model(1'b0, 1'b0, 1'b0, 58, 64, 64'h8000000001, 64'(sc_si), sc_di, so, dout);
            n_checks++;
            if (sc_do !== dout || sc_so !== 58'(so)) begin
                n_fail++;
                $display("FAIL scramble got %h/%h want %h/%h", sc_do, sc_so, dout, 58'(so));
            end
            n_checks++;
            if (ds_do !== sc_di) begin
                n_fail++;
                $display("FAIL descramble got %h want %h", ds_do, sc_di);
            end
            n_checks++;
            if (ds_so !== sc_so) begin
                n_fail++;
                $display("FAIL scr_state_match got %h want %h", ds_so, sc_so);
            end
        end
    endtask

    task automatic test_styles();
        logic [63:0] so, dout;
        for (int i = 0; i < 1000; i++) begin
            cm_si = 16'($urandom);
            cm_di = 24'($urandom);
            #1;
            for (int c = 0; c < 4; c++) begin
                model(c >= 2, c % 2 == 1, 1'b0, 16, 24, 64'h1021, 64'(cm_si), 64'(cm_di), so, dout);
                n_checks++;
                if (cm_so_l[c] !== cm_so_r[c] || cm_do_l[c] !== cm_do_r[c]) begin
                    n_fail++;
                    $display("FAIL style%0d loop %h/%h reduction %h/%h", c, cm_so_l[c], cm_do_l[c], cm_so_r[c], cm_do_r[c]);
                end
                n_checks++;
                if (cm_so_r[c] !== 16'(so) || cm_do_r[c] !== 24'(dout)) begin
                    n_fail++;
                    $display("FAIL model%0d got %h/%h want %h/%h", c, cm_so_r[c], cm_do_r[c], 16'(so), 24'(dout));
                end
            end
        end
    endtask

    task automatic test_registers();
        logic [63:0] so, dout;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_en = 1'b1;
        crc_si = 32'hFFFFFFFF;
        crc_di = 32'h0;
        model(1'b1, 1'b0, 1'b1, 32, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'h0, so, dout);
        @(posedge clk);
        #1;
        n_checks++;
        if (crc_so_reg !== 32'hDEBB20E3 || crc_do_reg !== 32'(dout)) begin
            n_fail++;
            $display("FAIL reg_capture got %h/%h want %h/%h", crc_so_reg, crc_do_reg, 32'hDEBB20E3, 32'(dout));
        end
        out_en = 1'b0;
        crc_di = $urandom | 32'h1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (crc_so_reg !== 32'hDEBB20E3 || crc_do_reg !== 32'(dout)) begin
            n_fail++;
            $display("FAIL reg_hold got %h/%h want %h/%h", crc_so_reg, crc_do_reg, 32'hDEBB20E3, 32'(dout));
        end
        n_checks++;
        if (crc_so !== crc_ref(32'hFFFFFFFF, crc_di)) begin
            n_fail++;
            $display("FAIL comb_during_hold got %h want %h", crc_so, crc_ref(32'hFFFFFFFF, crc_di));
        end
        rst = 1'b1;
        out_en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (crc_so_reg !== 32'h0 || crc_do_reg !== 32'h0) begin
            n_fail++;
            $display("FAIL reg_reset_priority got %h/%h want 0/0", crc_so_reg, crc_do_reg);
        end
        n_checks++;
        if (crc_so !== crc_ref(32'hFFFFFFFF, crc_di)) begin
            n_fail++;
            $display("FAIL comb_during_reset got %h want %h", crc_so, crc_ref(32'hFFFFFFFF, crc_di));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (crc_so_reg !== crc_ref(32'hFFFFFFFF, crc_di)) begin
            n_fail++;
            $display("FAIL reg_recapture got %h want %h", crc_so_reg, crc_ref(32'hFFFFFFFF, crc_di));
        end
    endtask

    initial begin
        sc_si = '0;
        sc_di = '0;
        cm_si = '0;
        cm_di = '0;
        test_reset();
        test_crc_vectors();
        test_crc_random();
        test_linearity();
        test_scrambler();
        test_styles();
        test_registers();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
